// File: rtl/cnn_run_controller_pkg.sv
// Shared definitions for the CNN run controller: FSM state encoding and display constants.
package cnn_run_controller_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DISP_ERR_CODE = 4'hE;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_RUN  = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } run_state_e;

endpackage

// File: rtl/cnn_run_controller_btn_debouncer.sv
// Start-button conditioning: 2-FF synchroniser, stable-sample debouncer and a
// one-cycle pulse on each accepted 0->1 transition of the debounced level.
module cnn_run_controller_btn_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_i,
  output logic go_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;
  logic             go_q;
  logic             accept;

  // The count tracks consecutive samples that disagree with the accepted level.
  assign accept = (sync_q[1] != level_q) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      go_q    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      go_q   <= accept && sync_q[1];
      if (sync_q[1] == level_q || accept) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (accept) begin
        level_q <= sync_q[1];
      end
    end
  end

  assign go_o = go_q;

endmodule

// File: rtl/cnn_run_controller.sv
// Run controller for the CNN core: button -> start pulse, done/timeout wait,
// latency measurement and digit/blank drive for the 7-seg stage.
//   state | meaning
//   IDLE  | after reset, display blanked, waiting for a press
//   ARM   | one-cycle cnn_start, latency counter cleared, display blanked
//   RUN   | counting cycles until cnn_done or timeout
//   DONE  | latched digit shown, result_valid held until next press
//   ERR   | error code shown, timeout_err held until next press
module cnn_run_controller
  import cnn_run_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1_000_000,
  parameter int CYC_W           = 24
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               btn_start,
  output logic               cnn_start,
  input  logic               cnn_done,
  input  logic [DIGIT_W-1:0] cnn_digit,
  output logic [DIGIT_W-1:0] disp_digit,
  output logic               disp_blank,
  output logic               busy,
  output logic               result_valid,
  output logic               timeout_err,
  output logic [CYC_W-1:0]   cycle_count
);

  localparam logic [CYC_W-1:0] TIMEOUT_C = CYC_W'(TIMEOUT_CYCLES);

  logic go;

  run_state_e         state_q, state_d;
  logic               cnn_start_q, cnn_start_d;
  logic [DIGIT_W-1:0] digit_q, digit_d;
  logic [DIGIT_W-1:0] disp_digit_q, disp_digit_d;
  logic               disp_blank_q, disp_blank_d;
  logic               busy_q, busy_d;
  logic               result_valid_q, result_valid_d;
  logic               timeout_err_q, timeout_err_d;
  logic [CYC_W-1:0]   cycle_count_q, cycle_count_d;

  cnn_run_controller_btn_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk    (clk),
    .reset_n(reset_n),
    .btn_i  (btn_start),
    .go_o   (go)
  );

  always_comb begin
    state_d       = state_q;
    digit_d       = digit_q;
    disp_digit_d  = disp_digit_q;
    disp_blank_d  = disp_blank_q;
    cycle_count_d = cycle_count_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: if (go) state_d = ST_ARM;
      ST_ARM:                   state_d = ST_RUN;
      ST_RUN: begin
        if (cycle_count_q != '1) cycle_count_d = cycle_count_q + CYC_W'(1);
        // Done is checked first so a done on the timeout cycle still reports a result.
        if (cnn_done) begin
          state_d = ST_DONE;
          digit_d = cnn_digit;
        end else if (cycle_count_d == TIMEOUT_C) begin
          state_d = ST_ERR;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cnn_start_d    = (state_d == ST_ARM);
    busy_d         = state_d inside {ST_ARM, ST_RUN};
    result_valid_d = (state_d == ST_DONE);
    timeout_err_d  = (state_d == ST_ERR);

    case (state_d)
      ST_ARM: begin
        cycle_count_d = '0;
        disp_blank_d  = 1'b1;
      end
      ST_DONE: begin
        disp_digit_d = digit_d;
        disp_blank_d = 1'b0;
      end
      ST_ERR: begin
        disp_digit_d = DISP_ERR_CODE;
        disp_blank_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      cnn_start_q    <= 1'b0;
      digit_q        <= '0;
      disp_digit_q   <= '0;
      disp_blank_q   <= 1'b1;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      cycle_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      cnn_start_q    <= cnn_start_d;
      digit_q        <= digit_d;
      disp_digit_q   <= disp_digit_d;
      disp_blank_q   <= disp_blank_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      timeout_err_q  <= timeout_err_d;
      cycle_count_q  <= cycle_count_d;
    end
  end

  assign cnn_start    = cnn_start_q;
  assign disp_digit   = disp_digit_q;
  assign disp_blank   = disp_blank_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign timeout_err  = timeout_err_q;
  assign cycle_count  = cycle_count_q;

endmodule
